// File: rtl/mux4_rr_arbiter.sv
// Four-source arbiter feeding one registered 32-bit output stage with valid/ready.
// Arbitration is round-robin or fixed priority; the winner's index travels with the word.
module mux4_rr_arbiter #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [3:0]      req_i,
  input  logic [size-1:0] data0_i,
  input  logic [size-1:0] data1_i,
  input  logic [size-1:0] data2_i,
  input  logic [size-1:0] data3_i,
  input  logic            mode_i,
  input  logic            ready_i,
  output logic [3:0]      grant_o,
  output logic            valid_o,
  output logic [size-1:0] data_o,
  output logic [1:0]      select_o
);

  logic [1:0]      ptr_q, ptr_d;
  logic            valid_q, valid_d;
  logic [size-1:0] data_q, data_d;
  logic [1:0]      select_q, select_d;

  logic            load_s;
  logic            grant_any_s;
  logic [1:0]      rr_idx_s;
  logic [1:0]      fix_idx_s;
  logic [1:0]      win_idx_s;
  logic [1:0]      cand_s;
  logic [size-1:0] win_data_s;
  logic [3:0]      grant_s;

  // Winner selection: both candidates computed, mode_i picks one in the same cycle.
  always_comb begin
    rr_idx_s  = ptr_q;
    fix_idx_s = 2'd0;
    cand_s    = 2'd0;
    // Descending scan so the nearest candidate to ptr (lowest offset) wins last.
    for (int i = 3; i >= 0; i--) begin
      cand_s = ptr_q + 2'(i);
      if (req_i[cand_s]) begin
        rr_idx_s = cand_s;
      end else begin
        rr_idx_s = rr_idx_s;
      end
      if (req_i[i]) begin
        fix_idx_s = 2'(i);
      end else begin
        fix_idx_s = fix_idx_s;
      end
    end
    if (mode_i) begin
      win_idx_s = fix_idx_s;
    end else begin
      win_idx_s = rr_idx_s;
    end
  end

  // Grant generation and source word mux; ready_i reaches grant_o through load_s only.
  always_comb begin
    load_s      = !valid_q || ready_i;
    grant_any_s = load_s && (|req_i);
    if (grant_any_s) begin
      grant_s = 4'b0001 << win_idx_s;
    end else begin
      grant_s = 4'b0000;
    end
    case (win_idx_s)
      2'd0:    win_data_s = data0_i;
      2'd1:    win_data_s = data1_i;
      2'd2:    win_data_s = data2_i;
      2'd3:    win_data_s = data3_i;
      default: win_data_s = data0_i;
    endcase
  end

  // Next-state for the output register and round-robin pointer.
  always_comb begin
    ptr_d    = ptr_q;
    valid_d  = valid_q;
    data_d   = data_q;
    select_d = select_q;
    if (grant_any_s) begin
      ptr_d    = win_idx_s + 2'd1;
      valid_d  = 1'b1;
      data_d   = win_data_s;
      select_d = win_idx_s;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers; reset discards any held word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q    <= 2'd0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      select_q <= 2'd0;
    end else begin
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      select_q <= select_d;
    end
  end

  assign grant_o  = grant_s;
  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign select_o = select_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: expected grants are checked combinationally,
// expected output words are queued at grant time and popped after the loading edge.
module tb_mux4_rr_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [31:0] data0_i, data1_i, data2_i, data3_i;
  logic        mode_i;
  logic        ready_i;
  logic [3:0]  grant_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic [1:0]  select_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [1:0]  last_sel;
  logic [31:0] last_data;

  mux4_rr_arbiter #(.size(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .data0_i  (data0_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .data3_i  (data3_i),
    .mode_i   (mode_i),
    .ready_i  (ready_i),
    .grant_o  (grant_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .select_o (select_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check grant, then check outputs after the edge.
  task automatic cyc(input string tag, input logic [3:0] req, input logic mode,
                     input logic ready, input logic [3:0] exp_grant, input logic exp_valid);
    exp_t e;
    @(negedge clk_i);
    req_i   = req;
    mode_i  = mode;
    ready_i = ready;
    #1;
    check({tag, ".grant"}, {60'd0, grant_o}, {60'd0, exp_grant});
    case (exp_grant)
      4'b0001: begin e.sel = 2'd0; e.data = data0_i; sb_q.push_back(e); end
      4'b0010: begin e.sel = 2'd1; e.data = data1_i; sb_q.push_back(e); end
      4'b0100: begin e.sel = 2'd2; e.data = data2_i; sb_q.push_back(e); end
      4'b1000: begin e.sel = 2'd3; e.data = data3_i; sb_q.push_back(e); end
      default: ;
    endcase
    @(posedge clk_i);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      last_sel  = e.sel;
      last_data = e.data;
    end
    check({tag, ".valid"},  {63'd0, valid_o},  {63'd0, exp_valid});
    check({tag, ".data"},   {32'd0, data_o},   {32'd0, last_data});
    check({tag, ".select"}, {62'd0, select_o}, {62'd0, last_sel});
  endtask

  initial begin
    rst_i     = 1'b0;
    req_i     = 4'b0000;
    mode_i    = 1'b0;
    ready_i   = 1'b0;
    data0_i   = 32'h10;
    data1_i   = 32'h11;
    data2_i   = 32'h12;
    data3_i   = 32'h13;
    last_sel  = 2'd0;
    last_data = 32'd0;

    repeat (2) @(posedge clk_i);
    #1;
    check("init.valid",  {63'd0, valid_o},  64'd0);
    check("init.data",   {32'd0, data_o},   64'd0);
    check("init.select", {62'd0, select_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Round-robin saturation from ptr=0
    cyc("rr0", 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1);
    cyc("rr1", 4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1);
    cyc("rr2", 4'b1111, 1'b0, 1'b1, 4'b0100, 1'b1);
    cyc("rr3", 4'b1111, 1'b0, 1'b1, 4'b1000, 1'b1);
    cyc("rr4", 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1);
    cyc("rr_drain", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);

    // Sparse pulse (ptr=1), leaves ptr=3
    cyc("sparse", 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1);
    cyc("sparse_idle0", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);
    cyc("sparse_idle1", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);

    // Pointer wrap: ptr=3 with 0101 -> 0, then ptr=1 -> 2
    cyc("wrap0", 4'b0101, 1'b0, 1'b1, 4'b0001, 1'b1);
    cyc("wrap1", 4'b0101, 1'b0, 1'b1, 4'b0100, 1'b1);
    cyc("wrap_drain", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);

    // Backpressure (ptr=3): load source 0, stall 3 cycles, then source 1
    cyc("bp_load", 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1);
    cyc("bp_hold0", 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1);
    cyc("bp_hold1", 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1);
    cyc("bp_hold2", 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1);
    cyc("bp_release", 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1);
    cyc("bp_drain", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);

    // Fixed priority (ptr=2 throughout), then round-robin picks source 3
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("fix%0d", i), 4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1);
    end
    cyc("fix_to_rr", 4'b1010, 1'b0, 1'b1, 4'b1000, 1'b1);
    cyc("fix_drain", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);

    // Asynchronous reset while a word is held
    data0_i = 32'hDEAD_BEEF;
    cyc("rst_load", 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1);
    cyc("rst_hold", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    check("rst.valid",  {63'd0, valid_o},  64'd0);
    check("rst.data",   {32'd0, data_o},   64'd0);
    check("rst.select", {62'd0, select_o}, 64'd0);
    sb_q.delete();
    last_sel  = 2'd0;
    last_data = 32'd0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    cyc("post_rst", 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b1);
    cyc("post_rst_drain", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
